// File: rtl/envelope_follower_pkg.sv
// Shared types and fixed-point helpers for the envelope follower.
package envelope_follower_pkg;

  localparam int unsigned AMPLITUDE_BITS = 16;

  typedef logic [AMPLITUDE_BITS-1:0] amplitude;

  // One-hot detector gate states.
  typedef enum logic [2:0] {
    StClosed = 3'b001,
    StOpen   = 3'b010,
    StHold   = 3'b100
  } gate_state_e;

  // Saturating absolute value of a sign-extended 'bits'-wide value: the most
  // negative code maps to the largest positive code instead of wrapping.
  function automatic logic signed [31:0] abs_sat(input logic signed [31:0] v,
                                                 input int unsigned bits);
    logic signed [31:0] max_pos;
    logic signed [31:0] mag;
    max_pos = (32'sd1 <<< (bits - 32'd1)) - 32'sd1;
    mag     = v[31] ? -v : v;
    return (mag > max_pos) ? max_pos : mag;
  endfunction

endpackage

// File: rtl/envelope_follower_muls.sv
// Full-precision signed multiplier: WIDTH x WIDTH -> 2*WIDTH.
module envelope_follower_muls #(
  parameter int unsigned WIDTH = 32
) (
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] product
);

  localparam int unsigned Wide = 2 * WIDTH;

  assign product = Wide'(a) * Wide'(b);

endmodule

// File: rtl/envelope_follower.sv
// Envelope follower: rectify, one-pole attack/release smoothing, and a
// hysteretic held gate derived from the smoothed level.
module envelope_follower
  import envelope_follower_pkg::*;
#(
  parameter int unsigned TOTAL_BITS      = 32,
  parameter int unsigned FRACTIONAL_BITS = 16,
  parameter int unsigned SAMPLE_BITS     = 16,
  parameter int unsigned HOLD_BITS       = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sample_valid,
  input  logic signed [SAMPLE_BITS-1:0] sample,
  input  logic signed [TOTAL_BITS-1:0]  attack_coef,
  input  logic signed [TOTAL_BITS-1:0]  release_coef,
  input  amplitude                      threshold,
  input  amplitude                      hysteresis,
  input  logic [HOLD_BITS-1:0]          hold_samples,
  output amplitude                      level,
  output logic                          level_valid,
  output logic                          gate,
  output logic                          active
);

  localparam int unsigned Wide   = 2 * TOTAL_BITS;
  localparam int unsigned XShift = FRACTIONAL_BITS - (SAMPLE_BITS - 1);
  localparam logic signed [TOTAL_BITS-1:0] One =
      TOTAL_BITS'((64'sd1 <<< FRACTIONAL_BITS) - 64'sd1);

  logic signed [TOTAL_BITS-1:0] x_d, x_q, y_d, y_q, coef, diff;
  logic signed [Wide-1:0]       prod, y_sum;
  logic signed [31:0]           mag;
  logic                         v1_q, v2_q;
  gate_state_e                  state_d, state_q;
  logic [HOLD_BITS-1:0]         cnt_d, cnt_q;
  amplitude                     low;

  // Rectify and align the sample to the fixed-point grid.
  always_comb begin
    mag = abs_sat(32'(sample), SAMPLE_BITS);
    x_d = TOTAL_BITS'(mag) <<< XShift;
  end

  // Stage 1: capture the rectified sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= sample_valid;
      if (sample_valid) x_q <= x_d;
    end
  end

  assign coef = (x_q > y_q) ? attack_coef : release_coef;
  assign diff = x_q - y_q;

  envelope_follower_muls #(
    .WIDTH (TOTAL_BITS)
  ) u_muls (
    .a       (diff),
    .b       (coef),
    .product (prod)
  );

  // One-pole update with clamping to the [0, one] envelope range.
  always_comb begin
    y_sum = Wide'(y_q) + (prod >>> FRACTIONAL_BITS);
    if (y_sum[Wide-1]) begin
      y_d = '0;
    end else if (y_sum > Wide'(One)) begin
      y_d = One;
    end else begin
      y_d = y_sum[TOTAL_BITS-1:0];
    end
  end

  // Stage 2: single-cycle level feedback register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_q  <= '0;
      v2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) y_q <= y_d;
    end
  end

  assign level       = y_q[FRACTIONAL_BITS-1 -: AMPLITUDE_BITS];
  assign level_valid = v2_q;
  assign low         = (threshold > hysteresis) ? amplitude'(threshold - hysteresis) : '0;

  // Gate next-state: only advances on cycles that publish a new level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (level_valid) begin
      unique case (state_q)
        StClosed: begin
          if (level >= threshold) state_d = StOpen;
        end
        StOpen: begin
          if (level < low) begin
            if (hold_samples == '0) begin
              state_d = StClosed;
            end else begin
              state_d = StHold;
              cnt_d   = hold_samples;
            end
          end
        end
        StHold: begin
          if (level >= threshold) begin
            state_d = StOpen;
            cnt_d   = '0;
          end else if (cnt_q <= HOLD_BITS'(1)) begin
            state_d = StClosed;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - HOLD_BITS'(1);
          end
        end
        default: begin
          state_d = StClosed;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Gate state and hold counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StClosed;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gate   = (state_q != StClosed);
  assign active = (level != '0) || (state_q != StClosed);

  // The smoothed level must never leave [0, one].
  assert property (@(posedge clk) disable iff (!reset_n) !y_q[TOTAL_BITS-1] && (y_q <= One));

endmodule

// File: tb/tb_envelope_follower.sv
// Self-checking bench for envelope_follower: directed scenarios plus a
// randomized stream compared against an arithmetic reference model.
module tb_envelope_follower;

  localparam longint OneFx = 65535;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               sample_valid = 1'b0;
  logic signed [15:0] sample = '0;
  logic signed [31:0] attack_coef = '0;
  logic signed [31:0] release_coef = '0;
  logic [15:0]        threshold = '0;
  logic [15:0]        hysteresis = '0;
  logic [15:0]        hold_samples = '0;
  logic [15:0]        level;
  logic               level_valid, gate, active;

  int checks = 0;
  int failures = 0;

  // Reference model state: smoothed level and gate (0 closed, 1 open, 2 hold).
  longint m_y = 0;
  int     m_state = 0;
  int     m_cnt = 0;

  always #5 clk = ~clk;

  envelope_follower dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .attack_coef  (attack_coef),
    .release_coef (release_coef),
    .threshold    (threshold),
    .hysteresis   (hysteresis),
    .hold_samples (hold_samples),
    .level        (level),
    .level_valid  (level_valid),
    .gate         (gate),
    .active       (active)
  );

  function automatic longint floor_div(longint a, longint b);
    longint q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // |sample| saturated to 32767, scaled into 16 fractional bits.
  function automatic longint rectify(logic signed [15:0] s);
    longint m = s;
    if (m < 0) m = -m;
    if (m > 32767) m = 32767;
    return m * 2;
  endfunction

  function automatic int model_sample(logic signed [15:0] s);
    longint x = rectify(s);
    longint c = (x > m_y) ? longint'(attack_coef) : longint'(release_coef);
    m_y = m_y + floor_div((x - m_y) * c, 65536);
    if (m_y < 0) m_y = 0;
    if (m_y > OneFx) m_y = OneFx;
    return int'(m_y);
  endfunction

  function automatic void model_gate(int lvl);
    int th = int'(threshold);
    int hy = int'(hysteresis);
    int lo = (th > hy) ? th - hy : 0;
    case (m_state)
      0: if (lvl >= th) m_state = 1;
      1: if (lvl < lo) begin
           if (hold_samples == 0) m_state = 0;
           else begin
             m_state = 2;
             m_cnt   = int'(hold_samples);
           end
         end
      default: if (lvl >= th) m_state = 1;
               else begin
                 m_cnt = m_cnt - 1;
                 if (m_cnt == 0) m_state = 0;
               end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    m_y = 0;
    m_state = 0;
    m_cnt = 0;
  endtask

  // One isolated sample: observe strobe timing, new level and gate response.
  task automatic push(input logic [15:0] s, output logic lv_early, output logic lv_on,
                      output logic [15:0] lvl, output logic g_at_lv, output logic g);
    sample = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    lv_early = level_valid;
    tick();
    lv_on = level_valid;
    lvl = level;
    g_at_lv = gate;
    tick();
    g = gate;
  endtask

  task automatic test_reset();
    logic e, o, ga, g;
    logic [15:0] l;
    tick();
    tick();
    checks++; if (level !== 16'h0) begin failures++; $display("FAIL reset_level got=%h want=0000", level); end
    checks++; if (level_valid !== 1'b0) begin failures++; $display("FAIL reset_lv got=%b want=0", level_valid); end
    checks++; if (gate !== 1'b0) begin failures++; $display("FAIL reset_gate got=%b want=0", gate); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b want=0", active); end
    reset_n = 1'b1;
    attack_coef = 32'h0000_FFFF;
    release_coef = 32'h0000_FFFF;
    threshold = 16'h0000;
    hysteresis = 16'h0000;
    hold_samples = 16'd2;
    tick();
    for (int i = 0; i < 6; i++) begin
      sample = 16'(16'h2000 + $urandom_range(0, 16'h3FFF));
      sample_valid = 1'b1;
      tick();
    end
    // Assert reset between edges with the stream still running.
    #2 reset_n = 1'b0;
    #1;
    checks++; if (level !== 16'h0) begin failures++; $display("FAIL midreset_level got=%h want=0000", level); end
    checks++; if (gate !== 1'b0) begin failures++; $display("FAIL midreset_gate got=%b want=0", gate); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL midreset_active got=%b want=0", active); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (level_valid !== 1'b0) begin failures++; $display("FAIL midreset_lv cycle=%0d got=%b want=0", i, level_valid); end
    end
    sample_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    threshold = 16'hFFFF;
    push(16'h1234, e, o, l, ga, g);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL postreset_early_lv got=%b want=0", e); end
    checks++; if (o !== 1'b1) begin failures++; $display("FAIL postreset_lv got=%b want=1", o); end
    checks++; if (l !== 16'h2467) begin failures++; $display("FAIL postreset_level got=%h want=2467", l); end
  endtask

  task automatic test_attack_full();
    logic e, o, ga, g;
    logic [15:0] l;
    do_reset();
    attack_coef = 32'h0000_FFFF;
    push(16'h4000, e, o, l, ga, g);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL attack_early_lv got=%b want=0", e); end
    checks++; if (o !== 1'b1) begin failures++; $display("FAIL attack_lv got=%b want=1", o); end
    checks++; if (l !== 16'h7FFF) begin failures++; $display("FAIL attack_level got=%h want=7fff", l); end
    checks++; if (level_valid !== 1'b0) begin failures++; $display("FAIL attack_lv_single got=%b want=0", level_valid); end
  endtask

  task automatic test_most_negative();
    logic e, o, ga, g;
    logic [15:0] l;
    do_reset();
    attack_coef = 32'h0000_FFFF;
    push(16'h8000, e, o, l, ga, g);
    checks++; if (l !== 16'hFFFD) begin failures++; $display("FAIL most_neg_level got=%h want=fffd", l); end
    // Zero coefficients freeze the level whatever the input does.
    attack_coef = 32'h0;
    release_coef = 32'h0;
    push(16'h1000, e, o, l, ga, g);
    checks++; if (l !== 16'hFFFD) begin failures++; $display("FAIL coef0_release got=%h want=fffd", l); end
    push(16'h7FFF, e, o, l, ga, g);
    checks++; if (l !== 16'hFFFD) begin failures++; $display("FAIL coef0_attack got=%h want=fffd", l); end
  endtask

  task automatic test_back_to_back();
    int n = 30;
    int lv_count = 0;
    int exp_lvl;
    logic [15:0] prev = 16'h0;
    logic prev_v = 1'b0;
    do_reset();
    attack_coef = 32'h0000_8000;
    release_coef = 32'h0000_8000;
    for (int k = 0; k < n + 3; k++) begin
      sample = 16'h4000;
      sample_valid = (k < n);
      tick();
      checks++;
      if (level_valid !== prev_v) begin failures++; $display("FAIL b2b_lv cycle=%0d got=%b want=%b", k, level_valid, prev_v); end
      if (level_valid) lv_count++;
      if (prev_v) begin
        exp_lvl = model_sample(16'h4000);
        checks++;
        if (level !== 16'(exp_lvl)) begin failures++; $display("FAIL b2b_level cycle=%0d got=%h want=%h", k, level, 16'(exp_lvl)); end
        checks++;
        if (level < prev || level > 16'h8000) begin failures++; $display("FAIL b2b_monotonic cycle=%0d got=%h prev=%h want<=8000", k, level, prev); end
        prev = level;
      end
      prev_v = (k < n);
    end
    checks++;
    if (lv_count != n) begin failures++; $display("FAIL b2b_count got=%0d want=%0d", lv_count, n); end
  endtask

  task automatic gate_seq(input string name, input int n, input logic [15:0] smp[8],
                          input logic [15:0] lvl[8], input logic gt[8], input logic start_gate);
    logic e, o, ga, g;
    logic [15:0] l;
    logic prev_g = start_gate;
    for (int i = 0; i < n; i++) begin
      push(smp[i], e, o, l, ga, g);
      checks++;
      if (o !== 1'b1 || e !== 1'b0) begin failures++; $display("FAIL %s_lv step=%0d got=%b%b want=01", name, i, e, o); end
      checks++;
      if (l !== lvl[i]) begin failures++; $display("FAIL %s_level step=%0d got=%h want=%h", name, i, l, lvl[i]); end
      checks++;
      if (ga !== prev_g) begin failures++; $display("FAIL %s_gate_early step=%0d got=%b want=%b", name, i, ga, prev_g); end
      checks++;
      if (g !== gt[i]) begin failures++; $display("FAIL %s_gate step=%0d got=%b want=%b", name, i, g, gt[i]); end
      prev_g = gt[i];
    end
  endtask

  task automatic test_gate_hold();
    logic [15:0] smp[8];
    logic [15:0] lvl[8];
    logic        gt[8];
    do_reset();
    attack_coef = 32'h0000_FFFF;
    release_coef = 32'h0000_FFFF;
    threshold = 16'h4000;
    hysteresis = 16'h1000;
    hold_samples = 16'd3;
    smp = '{16'h2800, 16'h1C00, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h0, 16'h0};
    lvl = '{16'h4FFF, 16'h3800, 16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h0, 16'h0};
    gt  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    gate_seq("hold", 6, smp, lvl, gt, 1'b0);
    // Re-open, drop into hold, then recover above threshold: must be OPEN
    // again, so lingering between low and threshold never closes.
    smp = '{16'h2800, 16'h1000, 16'h2001, 16'h1C00, 16'h1C00, 16'h1C00, 16'h1C00, 16'h0};
    lvl = '{16'h4FFF, 16'h2000, 16'h4001, 16'h3800, 16'h3800, 16'h3800, 16'h3800, 16'h0};
    gt  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    gate_seq("reopen", 7, smp, lvl, gt, 1'b0);
    hold_samples = 16'd0;
    smp = '{16'h1000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    lvl = '{16'h2000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    gt  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    gate_seq("nohold", 1, smp, lvl, gt, 1'b1);
    // Zero threshold: opens on the first update and stays open at level 0.
    threshold = 16'h0000;
    smp = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    lvl = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    gt  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    gate_seq("thr0", 4, smp, lvl, gt, 1'b0);
    checks++;
    if (active !== 1'b1) begin failures++; $display("FAIL thr0_active got=%b want=1", active); end
  endtask

  task automatic test_random();
    logic               v, prev_v;
    logic signed [15:0] s, prev_s;
    int                 g_before, lvl, pick;
    logic               exp_act;
    do_reset();
    prev_v = 1'b0;
    prev_s = '0;
    for (int b = 0; b < 8; b++) begin
      pick = $urandom_range(0, 3);
      attack_coef  = (pick == 0) ? 32'h0 : (pick == 1) ? 32'h0000_FFFF : 32'($urandom_range(0, 65535));
      pick = $urandom_range(0, 3);
      release_coef = (pick == 0) ? 32'h0 : (pick == 1) ? 32'h0000_FFFF : 32'($urandom_range(0, 65535));
      threshold    = 16'($urandom_range(0, 65535));
      hysteresis   = 16'($urandom_range(0, 16'h6000));
      hold_samples = 16'($urandom_range(0, 5));
      for (int k = 0; k < 64; k++) begin
        v = (k < 60) && ($urandom_range(0, 99) < ((b % 2 == 0) ? 100 : 65));
        s = 16'($urandom);
        sample = s;
        sample_valid = v;
        tick();
        checks++;
        if (gate !== (m_state != 0)) begin failures++; $display("FAIL rnd_gate burst=%0d cycle=%0d got=%b want=%b", b, k, gate, m_state != 0); end
        g_before = m_state;
        checks++;
        if (level_valid !== prev_v) begin failures++; $display("FAIL rnd_lv burst=%0d cycle=%0d got=%b want=%b", b, k, level_valid, prev_v); end
        if (prev_v) begin
          lvl = model_sample(prev_s);
          model_gate(lvl);
        end
        checks++;
        if (level !== 16'(m_y)) begin failures++; $display("FAIL rnd_level burst=%0d cycle=%0d got=%h want=%h", b, k, level, 16'(m_y)); end
        exp_act = (m_y != 0) || (g_before != 0);
        checks++;
        if (active !== exp_act) begin failures++; $display("FAIL rnd_active burst=%0d cycle=%0d got=%b want=%b", b, k, active, exp_act); end
        prev_v = v;
        prev_s = s;
      end
    end
  endtask

  initial begin
    test_reset();
    test_attack_full();
    test_most_negative();
    test_back_to_back();
    test_gate_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
